advtim_dtg_brk: RTL and testbench
=================================

// Module: advtim_dtg_brk
// PURPOSE
//  Output stage directly downstream of advtim_cnt_gen: takes oc1refc..oc4refc, builds complementary
//  CH1..CH3 / CH1N..CH3N pairs with programmable dead time, applies polarity, and enforces the break
//  (fault) path. Main-output-enable (MOE) state lives here; fault_detected feeds back to advtim_cnt_gen.
// PARAMETERS
//  DTW    8  dead-time counter width; dead time = r_dtg pe_gen_clk cycles
//  FLTW   4  break filter counter width
// PORTS
//  pe_gen_clk        in   1     block clock (same as advtim_cnt_gen)
//  pe_gen_rst        in   1     synchronous reset, active-high
//  oc1refc..oc4refc  in   1 ea  compare references from advtim_cnt_gen
//  pe_gen_hw_update  in   1     update pulse from advtim_cnt_gen (AOE re-arm point)
//  r_dtg             in   DTW   dead time in clocks
//  r_ccxe[3:0]       in   4     CH1..CH4 output enable
//  r_ccxne[2:0]      in   3     CH1N..CH3N output enable
//  r_ccxp[3:0]       in   4     CHx polarity (1 = active-low)
//  r_ccxnp[2:0]      in   3     CHxN polarity
//  r_ois[3:0]        in   4     CHx idle level when MOE=0
//  r_oisn[2:0]       in   3     CHxN idle level when MOE=0
//  r_moe             in   1     software MOE request; 0->1 edge sets MOE
//  r_aoe             in   1     automatic output enable at pe_gen_hw_update
//  r_bke             in   1     break enable
//  r_bkp             in   1     break polarity (1 = active-high)
//  r_bkf             in   FLTW  break filter: N+1 consecutive active samples required
//  brk_in            in   1     asynchronous break pin
//  ch_o[3:0]         out  4     CH1..CH4 pins
//  ch_on[2:0]        out  3     CH1N..CH3N pins
//  moe_active        out  1     current MOE state
//  fault_detected    out  1     1-cycle pulse on break entry (to advtim_cnt_gen)
//  int_status_break  out  1     1-cycle pulse, same cycle as fault_detected
// BEHAVIOUR
//  - Reset: all ch_o/ch_on = 0, moe_active=0, fault_detected=0, int_status_break=0, dt counters 0, FSM IDLE.
//  - Outputs registered: 1 cycle latency from refc to pin when r_dtg=0.
//  - Dead time (CH1..3, both CCxE and CCxNE set): on refc 0->1, OCxN drops next cycle, OCx rises after
//    r_dtg further cycles; on 1->0, OCx drops next cycle, OCxN rises after r_dtg cycles. Edge during a running
//    dead time reloads the counter; pulse shorter than r_dtg -> the delayed output never asserts. OCx and OCxN
//    never both active. Only one of pair enabled -> no dead time on that output. CH4: no N, no dead time.
//  - Enabled output: pin = internal ^ polarity; disabled output with MOE=1: pin = polarity (inactive).
//  - MOE FSM: IDLE (moe=0, pins = r_ois/r_oisn raw) -> RUN on r_moe rising edge, or on pe_gen_hw_update when
//    r_aoe=1, break not active. RUN -> BREAK when filtered break active and r_bke=1: pins at idle levels the
//    cycle after filter qualifies, fault_detected/int_status_break pulse once. BREAK -> IDLE when filtered
//    break deasserts. Break has priority over simultaneous MOE set/AOE in any state.
//  - Break sync: 2-flop synchroniser, then XOR r_bkp inversion, then filter counter saturating at r_bkf;
//    any inactive sample clears it. r_bkf=0 -> 1 sample (3 cycles pin-to-idle total).
//  - r_bke=0: break ignored, filter held clear. r_dtg changes take effect at next refc edge.
//  - Reset mid-operation: immediate return to reset values next clock regardless of state.
// STRUCTURE
//  - advtim_pkg: MOE FSM state enum (IDLE/RUN/BREAK), DTW/FLTW defaults.
//  - Sub-module advtim_dt_chan (refc, r_dtg, enables -> ocx, ocxn), instantiated 3x; break filter and MOE FSM
//    in top.
// TESTING
//  1 r_dtg=4, both enables, MOE=1, refc high 20 cycles -> CHxN low +1, CHx high +5; fall: CHx low +1, CHxN high +5.
//  2 r_dtg=8, refc pulse 5 cycles -> CHx stays 0; CHxN low exactly 5+8 cycles.
//  3 r_bke=1, r_bkp=1, r_bkf=3, brk_in high 3 cycles -> no break; 4 cycles -> pins = r_ois, one fault pulse.
//  4 Break active, r_aoe=1, pe_gen_hw_update pulses -> MOE stays 0; release break, next update -> RUN.
//  5 r_ccxp=1, CCxNE=0, r_dtg=6 -> ch_o = ~refc delayed 1, no dead time; ch_on = r_ccxnp.
//  6 Reset asserted in BREAK with dead time running -> all outputs 0, FSM IDLE next cycle.

Source files
------------

// File: rtl/advtim_pkg.sv
// Shared types and helpers for the advanced-timer output stage: MOE state encoding,
// default widths, and the per-pin level selection used for every CHx/CHxN output.
package advtim_pkg;

  localparam int DTW_DEF  = 8;
  localparam int FLTW_DEF = 4;

  typedef enum logic [1:0] {
    MOE_IDLE  = 2'd0,
    MOE_RUN   = 2'd1,
    MOE_BREAK = 2'd2
  } moe_state_e;

  // With MOE off the pin shows the raw idle level; with MOE on a disabled
  // output parks at its polarity level, i.e. electrically inactive.
  function automatic logic pin_level(
    input logic moe,
    input logic en,
    input logic act,
    input logic pol,
    input logic idle
  );
    logic lvl;
    if (!moe) begin
      lvl = idle;
    end else if (en) begin
      lvl = act ^ pol;
    end else begin
      lvl = pol;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/advtim_dt_chan.sv
// One complementary channel with dead-time insertion. Produces next-cycle active levels
// for OCx and OCxN; the top registers them into the pins.
module advtim_dt_chan #(
  parameter int DTW = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_refc,
  input  logic [DTW-1:0] i_dtg,
  input  logic           i_ccxe,
  input  logic           i_ccxne,
  output logic           o_ocx,
  output logic           o_ocxn
);

  logic           r_ref_p1;
  logic [DTW-1:0] r_cnt_p1;
  logic           w_edge;
  logic [DTW-1:0] w_cnt_nxt;
  logic           w_dt_on;
  logic           w_dt_done;

  // Any refc edge (re)loads the dead time, so a pulse shorter than the dead
  // time never lets the delayed side assert.
  assign w_edge    = i_refc ^ r_ref_p1;
  assign w_cnt_nxt = w_edge ? i_dtg :
                     ((r_cnt_p1 != '0) ? (r_cnt_p1 - DTW'(1)) : '0);
  assign w_dt_on   = i_ccxe & i_ccxne;
  assign w_dt_done = (w_cnt_nxt == '0) | ~w_dt_on;

  assign o_ocx  = i_refc & w_dt_done;
  assign o_ocxn = ~i_refc & w_dt_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ref_p1 <= 1'b0;
      r_cnt_p1 <= '0;
    end else begin
      r_ref_p1 <= i_refc;
      r_cnt_p1 <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/advtim_dtg_brk.sv
// Timer output stage: dead-time generation on CH1..CH3, polarity/enable on all pins,
// break input synchronisation and filtering, and the main-output-enable state machine.
module advtim_dtg_brk
  import advtim_pkg::*;
#(
  parameter int DTW  = DTW_DEF,
  parameter int FLTW = FLTW_DEF
) (
  input  logic            pe_gen_clk,
  input  logic            pe_gen_rst,
  input  logic            oc1refc,
  input  logic            oc2refc,
  input  logic            oc3refc,
  input  logic            oc4refc,
  input  logic            pe_gen_hw_update,
  input  logic [DTW-1:0]  r_dtg,
  input  logic [3:0]      r_ccxe,
  input  logic [2:0]      r_ccxne,
  input  logic [3:0]      r_ccxp,
  input  logic [2:0]      r_ccxnp,
  input  logic [3:0]      r_ois,
  input  logic [2:0]      r_oisn,
  input  logic            r_moe,
  input  logic            r_aoe,
  input  logic            r_bke,
  input  logic            r_bkp,
  input  logic [FLTW-1:0] r_bkf,
  input  logic            brk_in,
  output logic [3:0]      ch_o,
  output logic [2:0]      ch_on,
  output logic            moe_active,
  output logic            fault_detected,
  output logic            int_status_break
);

  logic [2:0]      w_refc;
  logic [2:0]      w_ocx;
  logic [2:0]      w_ocxn;
  logic [3:0]      w_oc_all;

  logic            r_brk_s1_p0;
  logic            r_brk_s2_p1;
  logic [FLTW-1:0] r_flt_p2;
  logic            r_moe_p0;
  logic            w_brk_act;
  logic            w_brk_flt;
  logic            w_moe_rise;
  logic            w_aoe_set;

  moe_state_e      r_state;
  moe_state_e      w_state_nxt;
  logic            w_moe_nxt;
  logic [3:0]      w_ch_nxt;
  logic [2:0]      w_chn_nxt;

  logic [3:0]      r_ch_o;
  logic [2:0]      r_ch_on;
  logic            r_moe_act;
  logic            r_fault;

  assign w_refc = {oc3refc, oc2refc, oc1refc};

  for (genvar g = 0; g < 3; g++) begin : g_dt
    advtim_dt_chan #(
      .DTW (DTW)
    ) u_dt (
      .i_clk   (pe_gen_clk),
      .i_rst   (pe_gen_rst),
      .i_refc  (w_refc[g]),
      .i_dtg   (r_dtg),
      .i_ccxe  (r_ccxe[g]),
      .i_ccxne (r_ccxne[g]),
      .o_ocx   (w_ocx[g]),
      .o_ocxn  (w_ocxn[g])
    );
  end

  // CH4 has no complement, so its reference goes straight to the pin logic.
  assign w_oc_all = {oc4refc, w_ocx};

  // Break path: p0/p1 synchroniser, p2 consecutive-sample filter
  assign w_brk_act  = r_brk_s2_p1 ^ ~r_bkp;
  assign w_brk_flt  = r_bke & w_brk_act & (r_flt_p2 >= r_bkf);
  assign w_moe_rise = r_moe & ~r_moe_p0;
  assign w_aoe_set  = r_aoe & pe_gen_hw_update;

  always_ff @(posedge pe_gen_clk) begin
    if (pe_gen_rst) begin
      r_brk_s1_p0 <= 1'b0;
      r_brk_s2_p1 <= 1'b0;
      r_flt_p2    <= '0;
      r_moe_p0    <= 1'b0;
    end else begin
      r_brk_s1_p0 <= brk_in;
      r_brk_s2_p1 <= r_brk_s1_p0;
      r_moe_p0    <= r_moe;
      if (!r_bke || !w_brk_act) begin
        r_flt_p2 <= '0;
      end else if (r_flt_p2 < r_bkf) begin
        r_flt_p2 <= r_flt_p2 + FLTW'(1);
      end
    end
  end

  // A qualified break blocks every way into RUN and forces RUN out to BREAK.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MOE_IDLE: begin
        if (!w_brk_flt && (w_moe_rise || w_aoe_set)) begin
          w_state_nxt = MOE_RUN;
        end
      end
      MOE_RUN: begin
        if (w_brk_flt) begin
          w_state_nxt = MOE_BREAK;
        end
      end
      MOE_BREAK: begin
        if (!w_brk_flt) begin
          w_state_nxt = MOE_IDLE;
        end
      end
      default: w_state_nxt = MOE_IDLE;
    endcase
  end

  assign w_moe_nxt = (w_state_nxt == MOE_RUN);

  always_comb begin
    w_ch_nxt  = '0;
    w_chn_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      w_ch_nxt[i] = pin_level(w_moe_nxt, r_ccxe[i], w_oc_all[i], r_ccxp[i], r_ois[i]);
    end
    for (int i = 0; i < 3; i++) begin
      w_chn_nxt[i] = pin_level(w_moe_nxt, r_ccxne[i], w_ocxn[i], r_ccxnp[i], r_oisn[i]);
    end
  end

  // Output stage: state, pins and status pulses registered together
  always_ff @(posedge pe_gen_clk) begin
    if (pe_gen_rst) begin
      r_state   <= MOE_IDLE;
      r_ch_o    <= '0;
      r_ch_on   <= '0;
      r_moe_act <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ch_o    <= w_ch_nxt;
      r_ch_on   <= w_chn_nxt;
      r_moe_act <= w_moe_nxt;
      r_fault   <= (r_state == MOE_RUN) && (w_state_nxt == MOE_BREAK);
    end
  end

  assign ch_o             = r_ch_o;
  assign ch_on            = r_ch_on;
  assign moe_active       = r_moe_act;
  assign fault_detected   = r_fault;
  assign int_status_break = r_fault;

endmodule

// File: tb/tb_advtim_dtg_brk.sv
// Directed bench for advtim_dtg_brk: the driver pushes hand-computed pin/status
// expectations per clock, an independent monitor pops and compares after each edge.
module tb_advtim_dtg_brk;

  logic       clk;
  logic       rst;
  logic [3:0] ref_v;
  logic       upd;
  logic [7:0] dtg;
  logic [3:0] ccxe;
  logic [2:0] ccxne;
  logic [3:0] ccxp;
  logic [2:0] ccxnp;
  logic [3:0] ois;
  logic [2:0] oisn;
  logic       moe_r;
  logic       aoe;
  logic       bke;
  logic       bkp;
  logic [3:0] bkf;
  logic       brk;

  logic [3:0] ch_o;
  logic [2:0] ch_on;
  logic       moe_active;
  logic       fault_detected;
  logic       int_status_break;

  localparam logic [3:0] IO  = 4'b1010;
  localparam logic [2:0] ION = 3'b101;

  typedef struct {
    logic       chk;
    logic [3:0] o;
    logic [2:0] on;
    logic       m;
    logic       f;
    int         tid;
    int         idx;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec;
  int   n_err;
  int   tid;
  int   vidx;

  advtim_dtg_brk #(
    .DTW  (8),
    .FLTW (4)
  ) dut (
    .pe_gen_clk       (clk),
    .pe_gen_rst       (rst),
    .oc1refc          (ref_v[0]),
    .oc2refc          (ref_v[1]),
    .oc3refc          (ref_v[2]),
    .oc4refc          (ref_v[3]),
    .pe_gen_hw_update (upd),
    .r_dtg            (dtg),
    .r_ccxe           (ccxe),
    .r_ccxne          (ccxne),
    .r_ccxp           (ccxp),
    .r_ccxnp          (ccxnp),
    .r_ois            (ois),
    .r_oisn           (oisn),
    .r_moe            (moe_r),
    .r_aoe            (aoe),
    .r_bke            (bke),
    .r_bkp            (bkp),
    .r_bkf            (bkf),
    .brk_in           (brk),
    .ch_o             (ch_o),
    .ch_on            (ch_on),
    .moe_active       (moe_active),
    .fault_detected   (fault_detected),
    .int_status_break (int_status_break)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic vec(input logic c, input logic [3:0] eo, input logic [2:0] eon,
                     input logic em, input logic ef);
    exp_t e;
    e.chk = c;
    e.o   = eo;
    e.on  = eon;
    e.m   = em;
    e.f   = ef;
    e.tid = tid;
    e.idx = vidx;
    q.push_back(e);
    vidx++;
    @(negedge clk);
  endtask

  task automatic start_test(input int t);
    tid  = t;
    vidx = 0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        if (mon_e.chk) begin
          n_vec++;
          if (ch_o !== mon_e.o || ch_on !== mon_e.on || moe_active !== mon_e.m ||
              fault_detected !== mon_e.f || int_status_break !== mon_e.f) begin
            n_err++;
            $display("FAIL t%0d v%0d got ch_o=%b ch_on=%b moe=%b fault=%b irq=%b want ch_o=%b ch_on=%b moe=%b fault/irq=%b",
                     mon_e.tid, mon_e.idx, ch_o, ch_on, moe_active, fault_detected,
                     int_status_break, mon_e.o, mon_e.on, mon_e.m, mon_e.f);
          end
        end
      end
    end
  end

  logic [3:0] pats [5];

  initial begin
    rst = 1'b1; ref_v = 4'h0; upd = 1'b0; dtg = 8'd4;
    ccxe = 4'hF; ccxne = 3'h7; ccxp = 4'h0; ccxnp = 3'h0;
    ois = IO; oisn = ION; moe_r = 1'b0; aoe = 1'b0;
    bke = 1'b0; bkp = 1'b1; bkf = 4'd3; brk = 1'b0;
    pats = '{4'b0101, 4'b1111, 4'b0000, 4'b1010, 4'b0011};

    // reset state, then idle levels, then software MOE set
    start_test(0);
    vec(1'b1, 4'b0000, 3'b000, 1'b0, 1'b0);
    vec(1'b1, 4'b0000, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    vec(1'b1, IO, ION, 1'b0, 1'b0);
    moe_r = 1'b1;
    vec(1'b1, 4'b0000, 3'b111, 1'b1, 1'b0);
    vec(1'b1, 4'b0000, 3'b111, 1'b1, 1'b0);

    // dead time 4 on both edges
    start_test(1);
    ref_v = 4'hF;
    for (int j = 0; j < 20; j++) vec(1'b1, (j < 4) ? 4'b1000 : 4'b1111, 3'b000, 1'b1, 1'b0);
    ref_v = 4'h0;
    for (int j = 0; j < 8; j++) vec(1'b1, 4'b0000, (j < 4) ? 3'b000 : 3'b111, 1'b1, 1'b0);

    // 5-cycle pulse under dead time 8
    start_test(2);
    dtg = 8'd8;
    vec(1'b1, 4'b0000, 3'b111, 1'b1, 1'b0);
    ref_v = 4'hF;
    for (int j = 0; j < 5; j++) vec(1'b1, 4'b1000, 3'b000, 1'b1, 1'b0);
    ref_v = 4'h0;
    for (int j = 5; j < 16; j++) vec(1'b1, 4'b0000, (j >= 13) ? 3'b111 : 3'b000, 1'b1, 1'b0);

    // active-low CHx, CHxN disabled: no dead time, CHxN parked at polarity
    start_test(5);
    ccxp = 4'hF; ccxne = 3'h0; ccxnp = 3'b101; dtg = 8'd6;
    vec(1'b1, 4'b1111, 3'b101, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      ref_v = pats[k];
      vec(1'b1, ~pats[k], 3'b101, 1'b1, 1'b0);
    end
    ccxp = 4'h0; ccxne = 3'h7; ccxnp = 3'h0; ref_v = 4'h0;
    for (int j = 0; j < 8; j++) vec(1'b0, 4'b0000, 3'b000, 1'b0, 1'b0);
    vec(1'b1, 4'b0000, 3'b111, 1'b1, 1'b0);

    // break filter: 3 active samples rejected, 4 qualify
    start_test(3);
    bke = 1'b1; bkp = 1'b1; bkf = 4'd3;
    vec(1'b1, 4'b0000, 3'b111, 1'b1, 1'b0);
    for (int j = 0; j < 10; j++) begin
      brk = (j < 3);
      vec(1'b1, 4'b0000, 3'b111, 1'b1, 1'b0);
    end
    for (int j = 0; j < 10; j++) begin
      brk = (j < 4);
      if (j < 5)       vec(1'b1, 4'b0000, 3'b111, 1'b1, 1'b0);
      else if (j == 5) vec(1'b1, IO, ION, 1'b0, 1'b1);
      else             vec(1'b1, IO, ION, 1'b0, 1'b0);
    end

    // AOE blocked while break active, takes effect after release
    start_test(4);
    aoe = 1'b1;
    for (int j = 0; j < 21; j++) begin
      brk = (j < 14);
      upd = (j == 8 || j == 12 || j == 15 || j == 20);
      if (j == 20) vec(1'b1, 4'b0000, 3'b111, 1'b1, 1'b0);
      else         vec(1'b1, IO, ION, 1'b0, 1'b0);
    end
    upd = 1'b0;

    // fastest break (filter 0) during dead time, then reset in BREAK
    start_test(6);
    moe_r = 1'b0; bkf = 4'd0; dtg = 8'd8; ref_v = 4'hF; brk = 1'b1;
    vec(1'b1, 4'b1000, 3'b000, 1'b1, 1'b0);
    vec(1'b1, 4'b1000, 3'b000, 1'b1, 1'b0);
    vec(1'b1, IO, ION, 1'b0, 1'b1);
    vec(1'b1, IO, ION, 1'b0, 1'b0);
    rst = 1'b1;
    vec(1'b1, 4'b0000, 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    vec(1'b1, IO, ION, 1'b0, 1'b0);
    ref_v = 4'h0; brk = 1'b0;
    vec(1'b1, IO, ION, 1'b0, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain queue left=%0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
